// File: rtl/wbu_pkg.sv
// -----------------------------------------------------------------------------
// wbu_pkg
//   Shared constants for the debug-bus TX path.
//   TAG_BUS / TAG_CONSOLE : value of bit 7 of a TX byte, identifying its source.
//   CHAR_W                : width of a source byte (7 bits).
//   TX_W                  : width of a tagged TX byte (8 bits).
//   tag_byte()            : builds a TX byte from a tag and a 7-bit payload.
// -----------------------------------------------------------------------------
package wbu_pkg;

    localparam logic TAG_BUS     = 1'b1;
    localparam logic TAG_CONSOLE = 1'b0;
    localparam int   CHAR_W      = 7;
    localparam int   TX_W        = 8;

    function automatic logic [TX_W-1:0] tag_byte(input logic tag,
                                                 input logic [CHAR_W-1:0] payload);
        return {tag, payload};
    endfunction

endpackage

// File: rtl/wbutx_confifo.sv
// -----------------------------------------------------------------------------
// wbutx_confifo
//   Synchronous FIFO buffering 7-bit console bytes so that console writers do
//   not stall while the debug bus owns the TX stream.
//
//   Ports
//     i_clk      in   system clock
//     i_reset_n  in   asynchronous active-low reset, empties the FIFO
//     i_push     in   write i_data (ignored while full)
//     i_data     in   byte to write
//     i_pop      in   discard the head entry (ignored while empty)
//     o_data     out  head entry, valid while o_empty_n
//     o_full     out  all 2**LGFIFO entries occupied
//     o_empty_n  out  at least one entry present
//
//   Flags come straight from the pointer registers, so a byte written in one
//   cycle is visible at the head only from the next cycle (no bypass).
// -----------------------------------------------------------------------------
module wbutx_confifo
    import wbu_pkg::*;
#(
    parameter int LGFIFO = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_push,
    input  logic [CHAR_W-1:0] i_data,
    input  logic              i_pop,
    output logic [CHAR_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty_n
);

    localparam logic [LGFIFO:0] PTR_ONE = 1;

    // One extra pointer bit distinguishes full from empty when the
    // address bits match.
    logic [LGFIFO:0]   wr_ptr;
    logic [LGFIFO:0]   rd_ptr;
    logic [CHAR_W-1:0] mem [0:(1<<LGFIFO)-1];
    logic              do_push;
    logic              do_pop;

    assign o_full    = (wr_ptr[LGFIFO] != rd_ptr[LGFIFO]) &&
                       (wr_ptr[LGFIFO-1:0] == rd_ptr[LGFIFO-1:0]);
    assign o_empty_n = (wr_ptr != rd_ptr);
    assign do_push   = i_push && !o_full;
    assign do_pop    = i_pop && o_empty_n;
    assign o_data    = mem[rd_ptr[LGFIFO-1:0]];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[LGFIFO-1:0]] <= i_data;
    end

endmodule

// File: rtl/wbutx_arbiter.sv
// -----------------------------------------------------------------------------
// wbutx_arbiter
//   Merges the debug-bus encoder byte stream (tag bit7=1) and the console byte
//   stream (tag bit7=0) onto one 8-bit TX stream. The bus has priority, but once
//   MAXBURST bus bytes have gone out while console data waits, the console is
//   granted one byte (o_starve pulses). Console bytes are buffered in a FIFO.
//
//   Ports
//     i_clk, i_reset_n          clock, asynchronous active-low reset
//     i_bus_stb, i_bus_data     bus byte offer (7 bits)
//     o_bus_busy                bus byte not taken this cycle
//     i_console_stb, i_console_data  console byte offer (7 bits)
//     o_console_busy            console FIFO full
//     o_tx_stb, o_tx_data       tagged TX byte, held until accepted
//     i_tx_busy                 TX cannot take the byte this cycle
//     o_starve                  console grant forced by the burst limit
//
//   Handshake rule for every stream: a byte moves on a cycle where its
//   valid is high and the matching busy is low; a held TX byte keeps
//   o_tx_stb/o_tx_data unchanged until that happens.
// -----------------------------------------------------------------------------
module wbutx_arbiter
    import wbu_pkg::*;
#(
    parameter int LGCONFIFO = 4,
    parameter int MAXBURST  = 16,
    parameter int LGBURST   = 5
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_bus_stb,
    input  logic [CHAR_W-1:0] i_bus_data,
    output logic              o_bus_busy,
    input  logic              i_console_stb,
    input  logic [CHAR_W-1:0] i_console_data,
    output logic              o_console_busy,
    output logic              o_tx_stb,
    output logic [TX_W-1:0]   o_tx_data,
    input  logic              i_tx_busy,
    output logic              o_starve
);

    localparam logic [LGBURST-1:0] BURST_LIMIT = LGBURST'(MAXBURST);
    localparam logic [LGBURST-1:0] CNT_MAX     = '1;
    localparam logic [LGBURST-1:0] CNT_ONE     = 1;

    logic [CHAR_W-1:0]  fifo_data;
    logic               fifo_full;
    logic               fifo_empty_n;
    logic [LGBURST-1:0] count;
    logic               load_ok;
    logic               force_console;
    logic               grant_bus;
    logic               grant_console;
    logic               console_push;

    // The holding register may be reloaded when empty or on the very cycle
    // its byte is taken, giving back-to-back bytes with no bubble.
    assign load_ok       = !o_tx_stb || !i_tx_busy;
    // Derived only from registers so o_bus_busy never depends on i_bus_stb.
    assign force_console = fifo_empty_n && (count >= BURST_LIMIT);

    assign grant_console = load_ok && (force_console || (!i_bus_stb && fifo_empty_n));
    assign grant_bus     = load_ok && !force_console && i_bus_stb;

    assign o_bus_busy     = !load_ok || force_console;
    assign o_starve       = load_ok && force_console;
    assign console_push   = i_console_stb && !fifo_full;
    assign o_console_busy = fifo_full;

    wbutx_confifo #(
        .LGFIFO (LGCONFIFO)
    ) u_confifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (console_push),
        .i_data    (i_console_data),
        .i_pop     (grant_console),
        .o_data    (fifo_data),
        .o_full    (fifo_full),
        .o_empty_n (fifo_empty_n)
    );

    // Burst counter: counts bus grants only while console data is pending,
    // so a console byte arriving mid-stream waits at most MAXBURST bus bytes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (!fifo_empty_n && !console_push) begin
            count <= '0;
        end else if (grant_console) begin
            count <= '0;
        end else if (grant_bus && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

    // Output holding register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_tx_stb  <= 1'b0;
            o_tx_data <= '0;
        end else if (load_ok) begin
            if (grant_bus) begin
                o_tx_stb  <= 1'b1;
                o_tx_data <= tag_byte(TAG_BUS, i_bus_data);
            end else if (grant_console) begin
                o_tx_stb  <= 1'b1;
                o_tx_data <= tag_byte(TAG_CONSOLE, fifo_data);
            end else begin
                o_tx_stb  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wbutx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wbutx_arbiter
//   Directed scenarios plus randomized traffic. A reference model tracks the
//   console FIFO as a queue and the burst count as an integer, and pushes each
//   granted TX byte into exp_q; the monitor pops on every TX accept.
// -----------------------------------------------------------------------------
module tb_wbutx_arbiter;

    localparam int MAXB  = 16;
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bus_stb = 1'b0;
    logic [6:0] bus_data = '0;
    logic       con_stb = 1'b0;
    logic [6:0] con_data = '0;
    logic       tx_busy = 1'b0;
    logic       bus_busy;
    logic       con_busy;
    logic       tx_stb;
    logic [7:0] tx_data;
    logic       starve;

    always #5 clk = ~clk;

    wbutx_arbiter #(
        .LGCONFIFO (4),
        .MAXBURST  (16),
        .LGBURST   (5)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_bus_stb      (bus_stb),
        .i_bus_data     (bus_data),
        .o_bus_busy     (bus_busy),
        .i_console_stb  (con_stb),
        .i_console_data (con_data),
        .o_console_busy (con_busy),
        .o_tx_stb       (tx_stb),
        .o_tx_data      (tx_data),
        .i_tx_busy      (tx_busy),
        .o_starve       (starve)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    logic [6:0] m_fifo[$];
    int         m_count = 0;
    logic       m_stb = 1'b0;
    int         starve_cnt = 0;
    int         gap_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk or negedge rst_n) begin : model
        bit         ld;
        bit         ne;
        bit         frc;
        bit         psh;
        logic [6:0] head;
        if (!rst_n) begin
            m_fifo.delete();
            exp_q.delete();
            m_count = 0;
            m_stb   = 1'b0;
        end else begin
            ld  = !m_stb || !tx_busy;
            ne  = m_fifo.size() > 0;
            frc = ne && (m_count >= MAXB);
            psh = con_stb && (m_fifo.size() < DEPTH);
            if (ld) begin
                if (frc || (!bus_stb && ne)) begin
                    head = m_fifo.pop_front();
                    exp_q.push_back({1'b0, head});
                    m_count = 0;
                    m_stb   = 1'b1;
                end else if (bus_stb) begin
                    exp_q.push_back({1'b1, bus_data});
                    m_count = (m_count < 31) ? m_count + 1 : 31;
                    m_stb   = 1'b1;
                end else begin
                    m_stb = 1'b0;
                end
            end
            if (!ne && !psh) m_count = 0;
            if (psh) m_fifo.push_back(con_data);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        bit ld;
        bit frc;
        if (!rst_n) begin
            check("rst_tx_stb", 32'(tx_stb), 32'(0));
            check("rst_tx_data", 32'(tx_data), 32'(0));
            check("rst_console_busy", 32'(con_busy), 32'(0));
            check("rst_starve", 32'(starve), 32'(0));
        end else begin
            ld  = !m_stb || !tx_busy;
            frc = (m_fifo.size() > 0) && (m_count >= MAXB);
            check("tx_stb", 32'(tx_stb), 32'(m_stb));
            check("bus_busy", 32'(bus_busy), 32'(!ld || frc));
            check("console_busy", 32'(con_busy), 32'(m_fifo.size() == DEPTH));
            check("starve", 32'(starve), 32'(ld && frc));
            if (starve) starve_cnt++;
            if (!tx_stb) gap_cnt++;
            if (tx_stb) begin
                if (exp_q.size() == 0) begin
                    check("tx_unexpected", 32'(tx_stb), 32'(0));
                end else begin
                    check("tx_data", 32'(tx_data), 32'(exp_q[0]));
                    if (!tx_busy) begin
                        log_q.push_back(tx_data);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_stb = 1'b0;
        con_stb = 1'b0;
        tx_busy = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int bus_pct;
        int tx_pct;
        int busn;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Two console bytes with TX idle.
        log_q.delete();
        con_stb = 1'b1; con_data = 7'h41; step();
        con_data = 7'h42; step();
        con_stb = 1'b0;
        repeat (6) step();
        check("t1_count", 32'(log_q.size()), 32'(2));
        if (log_q.size() >= 2) begin
            check("t1_byte0", 32'(log_q[0]), 32'h41);
            check("t1_byte1", 32'(log_q[1]), 32'h42);
        end

        // Simultaneous bus and console offers.
        log_q.delete();
        bus_stb = 1'b1; bus_data = 7'h23;
        con_stb = 1'b1; con_data = 7'h30;
        step();
        bus_stb = 1'b0; con_stb = 1'b0;
        repeat (6) step();
        check("t2_count", 32'(log_q.size()), 32'(2));
        if (log_q.size() >= 2) begin
            check("t2_bus_first", 32'(log_q[0]), 32'hA3);
            check("t2_console_second", 32'(log_q[1]), 32'h30);
        end

        // Burst limit with a continuous bus stream; also zero-bubble reload.
        bus_stb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_data = 7'($urandom_range(0, 127));
            step();
        end
        con_stb = 1'b1; con_data = 7'h55;
        bus_data = 7'($urandom_range(0, 127));
        step();
        con_stb = 1'b0;
        log_q.delete(); starve_cnt = 0; gap_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            bus_data = 7'($urandom_range(0, 127));
            step();
        end
        bus_stb = 1'b0;
        check("t3_starve_pulses", 32'(starve_cnt), 32'(1));
        check("t3_no_gap", 32'(gap_cnt), 32'(0));
        check("t3_count", 32'(log_q.size()), 32'(20));
        if (log_q.size() >= 18) begin
            busn = 0;
            for (int i = 0; i < 16; i++) if (log_q[i][7]) busn++;
            check("t3_bus_before", 32'(busn), 32'(16));
            check("t3_console", 32'(log_q[16]), 32'h55);
            check("t3_bus_resumes", 32'(log_q[17][7]), 32'(1));
        end
        repeat (4) step();

        // FIFO fill while TX is stalled, then in-order drain.
        log_q.delete();
        tx_busy = 1'b1;
        bus_stb = 1'b1; bus_data = 7'h11;
        step();
        bus_stb = 1'b0;
        for (int i = 0; i < 17; i++) begin
            con_stb = 1'b1;
            con_data = 7'(8'h60 + i);
            check("t4_console_busy", 32'(con_busy), 32'(i == 16));
            step();
        end
        con_stb = 1'b0;
        repeat (2) step();
        tx_busy = 1'b0;
        repeat (25) step();
        check("t4_count", 32'(log_q.size()), 32'(17));
        if (log_q.size() == 17) begin
            check("t4_bus_held", 32'(log_q[0]), 32'h91);
            for (int j = 0; j < 16; j++)
                check("t4_drain_order", 32'(log_q[j+1]), 32'(8'h60 + j));
        end

        // Reset mid-operation with a held byte and five queued console bytes.
        tx_busy = 1'b1;
        bus_stb = 1'b1; bus_data = 7'h22;
        step();
        bus_stb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            con_stb = 1'b1; con_data = 7'(8'h70 + i);
            step();
        end
        con_stb = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("t5_async_tx_stb", 32'(tx_stb), 32'(0));
        step();
        rst_n = 1'b1;
        tx_busy = 1'b0;
        log_q.delete();
        bus_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_data = 7'($urandom_range(0, 127));
            step();
        end
        bus_stb = 1'b0;
        repeat (6) step();
        check("t5_count", 32'(log_q.size()), 32'(10));
        busn = 0;
        foreach (log_q[i]) if (log_q[i][7]) busn++;
        check("t5_no_stale_console", 32'(busn), 32'(log_q.size()));

        // Randomized traffic in phases of differing bus / TX pressure.
        for (int ph = 0; ph < 6; ph++) begin
            bus_pct = (ph % 3 == 0) ? 95 : ((ph % 3 == 1) ? 60 : 20);
            tx_pct  = (ph < 3) ? 10 : 50;
            for (int c = 0; c < 400; c++) begin
                bus_stb  = ($urandom_range(0, 99) < bus_pct);
                bus_data = 7'($urandom_range(0, 127));
                con_stb  = ($urandom_range(0, 99) < 35);
                con_data = 7'($urandom_range(0, 127));
                tx_busy  = ($urandom_range(0, 99) < tx_pct);
                step();
            end
        end

        // Drain, bounded.
        idle_inputs();
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0 && m_fifo.size() == 0) break;
            step();
        end
        step();
        check("drain_pending", 32'(exp_q.size() + m_fifo.size()), 32'(0));
        check("drain_tx_idle", 32'(tx_stb), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
